// File: rtl/gpio_arb_pkg.sv
// rtl/gpio_arb_pkg.sv - shared state encoding and gpio address-window helpers for gpio_bus_arbiter
package gpio_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_RD_CAP = 2'd2
  } arb_state_e;

  localparam logic [1:0] GPIO_ADDR_DATA = 2'd0;
  localparam logic [1:0] GPIO_ADDR_DIRS = 2'd1;

  // Only the DATA and DIRS word windows exist; anything else is answered with err.
  function automatic logic addr_ok(input logic [1:0] word);
    return (word == GPIO_ADDR_DATA) || (word == GPIO_ADDR_DIRS);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin one-hot grant, search starts just after last winner
module rr_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int ID_WIDTH = 1
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] last,
  output logic [NUM_REQ-1:0]  grant,
  output logic [ID_WIDTH-1:0] grant_id
);

  logic found;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!found && req[k] && (k == ((int'(last) + i) % NUM_REQ))) begin
          grant[k] = 1'b1;
          grant_id = ID_WIDTH'(k);
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/gpio_bus_arbiter.sv
// rtl/gpio_bus_arbiter.sv - shares one gpio_module register port between NUM_REQ requesters
module gpio_bus_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int ID_WIDTH = 1
) (
  input  logic                    sysclk_i,
  input  logic                    reset_n_i,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  input  logic [NUM_REQ-1:0]      req_write_i,
  input  logic [4*NUM_REQ-1:0]    req_addr_i,
  input  logic [4*NUM_REQ-1:0]    req_byte_sel_i,
  input  logic [32*NUM_REQ-1:0]   req_wdata_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  output logic                    rsp_valid_o,
  output logic [ID_WIDTH-1:0]     rsp_id_o,
  output logic                    rsp_write_o,
  output logic                    rsp_err_o,
  output logic [31:0]             rsp_rdata_o,
  output logic                    wr_ena_o,
  output logic [3:0]              wr_addr_o,
  output logic [3:0]              wr_byte_sel_o,
  output logic [31:0]             wr_data_o,
  output logic                    rd_ena_o,
  output logic [3:0]              rd_addr_o,
  input  logic [31:0]             rd_data_i
);
  import gpio_arb_pkg::*;

  arb_state_e          state_q, state_d;
  logic [ID_WIDTH-1:0] last_q, last_d, cmd_id_q, cmd_id_d;
  logic                cmd_write_q, cmd_write_d, cmd_err_q, cmd_err_d;

  logic [NUM_REQ-1:0]  grant;
  logic [ID_WIDTH-1:0] grant_id;
  logic                win_write;
  logic [3:0]          win_addr, win_sel;
  logic [31:0]         win_wdata;

  logic [NUM_REQ-1:0]  ready_d;
  logic                rsp_valid_d, rsp_write_d, rsp_err_d;
  logic [ID_WIDTH-1:0] rsp_id_d;
  logic [31:0]         rsp_rdata_d;
  logic                wr_ena_d, rd_ena_d;
  logic [3:0]          wr_addr_d, wr_sel_d, rd_addr_d;
  logic [31:0]         wr_data_d;

  rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr_arbiter (
    .req      (req_valid_i),
    .last     (last_q),
    .grant    (grant),
    .grant_id (grant_id)
  );

  always_comb begin
    win_write = 1'b0;
    win_addr  = '0;
    win_sel   = '0;
    win_wdata = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) begin
        win_write = req_write_i[k];
        win_addr  = req_addr_i[4*k +: 4];
        win_sel   = req_byte_sel_i[4*k +: 4];
        win_wdata = req_wdata_i[32*k +: 32];
      end
    end
  end

  // Outputs are computed one cycle ahead so every port comes straight from a flop.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cmd_id_d    = cmd_id_q;
    cmd_write_d = cmd_write_q;
    cmd_err_d   = cmd_err_q;
    ready_d     = '0;
    wr_ena_d    = 1'b0;
    wr_addr_d   = '0;
    wr_sel_d    = '0;
    wr_data_d   = '0;
    rd_ena_d    = 1'b0;
    rd_addr_d   = '0;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_o;
    rsp_write_d = rsp_write_o;
    rsp_err_d   = rsp_err_o;
    rsp_rdata_d = rsp_rdata_o;

    case (state_q)
      ST_IDLE: begin
        if (|req_valid_i) begin
          state_d     = ST_ISSUE;
          last_d      = grant_id;
          cmd_id_d    = grant_id;
          cmd_write_d = win_write;
          cmd_err_d   = !addr_ok(win_addr[3:2]);
          ready_d     = grant;
          if (addr_ok(win_addr[3:2])) begin
            if (win_write) begin
              wr_ena_d  = 1'b1;
              wr_addr_d = win_addr;
              wr_sel_d  = win_sel;
              wr_data_d = win_wdata;
            end else begin
              rd_ena_d  = 1'b1;
              rd_addr_d = win_addr;
            end
          end
        end
      end
      ST_ISSUE: begin
        if (cmd_write_q || cmd_err_q) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b1;
          rsp_id_d    = cmd_id_q;
          rsp_write_d = cmd_write_q;
          rsp_err_d   = cmd_err_q;
          rsp_rdata_d = '0;
        end else begin
          state_d = ST_RD_CAP;
        end
      end
      ST_RD_CAP: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b1;
        rsp_id_d    = cmd_id_q;
        rsp_write_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = rd_data_i;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sysclk_i) begin
    if (!reset_n_i) begin
      state_q       <= ST_IDLE;
      last_q        <= ID_WIDTH'(NUM_REQ - 1);
      cmd_id_q      <= '0;
      cmd_write_q   <= 1'b0;
      cmd_err_q     <= 1'b0;
      req_ready_o   <= '0;
      rsp_valid_o   <= 1'b0;
      rsp_id_o      <= '0;
      rsp_write_o   <= 1'b0;
      rsp_err_o     <= 1'b0;
      rsp_rdata_o   <= '0;
      wr_ena_o      <= 1'b0;
      wr_addr_o     <= '0;
      wr_byte_sel_o <= '0;
      wr_data_o     <= '0;
      rd_ena_o      <= 1'b0;
      rd_addr_o     <= '0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      cmd_id_q      <= cmd_id_d;
      cmd_write_q   <= cmd_write_d;
      cmd_err_q     <= cmd_err_d;
      req_ready_o   <= ready_d;
      rsp_valid_o   <= rsp_valid_d;
      rsp_id_o      <= rsp_id_d;
      rsp_write_o   <= rsp_write_d;
      rsp_err_o     <= rsp_err_d;
      rsp_rdata_o   <= rsp_rdata_d;
      wr_ena_o      <= wr_ena_d;
      wr_addr_o     <= wr_addr_d;
      wr_byte_sel_o <= wr_sel_d;
      wr_data_o     <= wr_data_d;
      rd_ena_o      <= rd_ena_d;
      rd_addr_o     <= rd_addr_d;
    end
  end

endmodule
